// File: rtl/rmon_trig_pkg.sv
// Shared types and constants for the multi-channel RMON trigger generator:
// channel state encoding, LFSR taps and per-channel seed derivation.
package rmon_trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECIDE = 2'd1,
        ST_PULSE  = 2'd2,
        ST_GAP    = 2'd3
    } chan_state_t;

    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [15:0] SEED_BASE   = 16'hACE1;
    localparam logic [15:0] SEED_STRIDE = 16'h1F35;

    function automatic logic [15:0] f_chan_seed(input int unsigned idx);
        logic [31:0] w_prod;
        logic [15:0] w_seed;
        w_prod = 32'(idx) * {16'h0000, SEED_STRIDE};
        w_seed = SEED_BASE ^ w_prod[15:0];
        if (w_seed == 16'h0000) begin
            w_seed = 16'h0001;
        end else begin
            w_seed = w_seed;
        end
        return w_seed;
    endfunction

endpackage

// File: rtl/rmon_trig_chan.sv
// One trigger channel: free-running LFSR plus the IDLE/DECIDE/PULSE/GAP
// sequencer that spaces pulses by at least one minimum-size frame.
module rmon_trig_chan
    import rmon_trig_pkg::*;
#(
    parameter int          g_prob_width = 7,
    parameter int          g_min_gap    = 32,
    parameter int          g_idle_bits  = 3,
    parameter int          g_idle_unit  = 2,
    parameter logic [15:0] g_seed       = 16'hACE1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic [g_prob_width-1:0] prob_i,
    output logic                    pulse_o
);

    localparam int GAP_LOAD = g_min_gap - 2;
    localparam int GAP_W    = (g_min_gap > 2) ? $clog2(g_min_gap) : 1;
    localparam int IDLE_MAX = ((2 ** g_idle_bits) - 1) * g_idle_unit;
    localparam int IDLE_W   = (IDLE_MAX > 0) ? $clog2(IDLE_MAX + 1) : 1;

    chan_state_t       r_state;
    chan_state_t       w_state_nx;
    logic [15:0]       r_lfsr;
    logic [15:0]       w_lfsr_nx;
    logic [IDLE_W-1:0] r_idle;
    logic [IDLE_W-1:0] w_idle_nx;
    logic [IDLE_W-1:0] w_idle_load;
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  w_gap_nx;
    logic              w_fire;

    assign w_lfsr_nx   = {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
    assign w_idle_load = IDLE_W'(32'(r_lfsr[15 -: g_idle_bits]) * 32'(g_idle_unit));
    assign w_fire      = (&prob_i) || (r_lfsr[g_prob_width-1:0] < prob_i);
    assign pulse_o     = (r_state == ST_PULSE) && en_i;

    // Next-state logic; GAP ends when its counter decrements to zero so the
    // next decision lands exactly g_min_gap cycles after the pulse.
    always_comb begin
        w_state_nx = r_state;
        w_idle_nx  = r_idle;
        w_gap_nx   = r_gap;
        case (r_state)
            ST_IDLE: begin
                if (r_idle != '0) begin
                    w_idle_nx = r_idle - IDLE_W'(1);
                end else begin
                    w_state_nx = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                if (w_fire) begin
                    w_state_nx = ST_PULSE;
                end else begin
                    w_idle_nx  = w_idle_load;
                    w_state_nx = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (GAP_LOAD == 0) begin
                    w_idle_nx  = w_idle_load;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_gap_nx   = GAP_W'(GAP_LOAD);
                    w_state_nx = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap <= GAP_W'(1)) begin
                    w_gap_nx   = '0;
                    w_idle_nx  = w_idle_load;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_gap_nx   = r_gap - GAP_W'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_idle_nx  = '0;
                w_gap_nx   = '0;
            end
        endcase
    end

    // Channel state register; everything holds while en_i is low
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_lfsr  <= g_seed;
            r_idle  <= '0;
            r_gap   <= '0;
        end else if (en_i) begin
            r_state <= w_state_nx;
            r_lfsr  <= w_lfsr_nx;
            r_idle  <= w_idle_nx;
            r_gap   <= w_gap_nx;
        end else begin
            r_state <= r_state;
            r_lfsr  <= r_lfsr;
            r_idle  <= r_idle;
            r_gap   <= r_gap;
        end
    end

endmodule

// File: rtl/rmon_trig_gen_mc.sv
// Multi-channel pseudo-random event-pulse generator: per-channel pulse
// sequencers gated by a run window, with a running count of emitted pulses.
module rmon_trig_gen_mc
    import rmon_trig_pkg::*;
#(
    parameter int g_trig_width = 10,
    parameter int g_prob_width = 7,
    parameter int g_min_gap    = 32,
    parameter int g_idle_bits  = 3,
    parameter int g_idle_unit  = 2,
    parameter int g_cnt_width  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic [g_prob_width-1:0] prob_i,
    input  logic [31:0]             run_len_i,
    input  logic                    start_i,
    input  logic                    stop_i,
    output logic [g_trig_width-1:0] trig_o,
    output logic                    active_o,
    output logic [g_cnt_width-1:0]  pulse_cnt_o
);

    logic [g_trig_width-1:0] w_pulse;
    logic [g_trig_width-1:0] r_trig;
    logic                    r_active;
    logic                    w_active_nx;
    logic [31:0]             r_win_cnt;
    logic [31:0]             w_win_nx;
    logic [g_cnt_width-1:0]  r_pulse_cnt;
    logic [g_cnt_width-1:0]  w_pop;

    for (genvar gi = 0; gi < g_trig_width; gi++) begin : g_chan
        rmon_trig_chan #(
            .g_prob_width (g_prob_width),
            .g_min_gap    (g_min_gap),
            .g_idle_bits  (g_idle_bits),
            .g_idle_unit  (g_idle_unit),
            .g_seed       (f_chan_seed(gi))
        ) u_chan (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .en_i    (en_i),
            .prob_i  (prob_i),
            .pulse_o (w_pulse[gi])
        );
    end

    // Run window: stop beats start; a zero window count while active means unlimited
    always_comb begin
        w_active_nx = r_active;
        w_win_nx    = r_win_cnt;
        if (stop_i) begin
            w_active_nx = 1'b0;
            w_win_nx    = 32'd0;
        end else if (start_i) begin
            w_active_nx = 1'b1;
            w_win_nx    = run_len_i;
        end else if (r_active && (r_win_cnt != 32'd0)) begin
            w_win_nx = r_win_cnt - 32'd1;
            if (r_win_cnt == 32'd1) begin
                w_active_nx = 1'b0;
            end else begin
                w_active_nx = 1'b1;
            end
        end else begin
            w_active_nx = r_active;
            w_win_nx    = r_win_cnt;
        end
    end

    // Number of pulses presented on trig_o this cycle
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < g_trig_width; i++) begin
            w_pop = w_pop + {{(g_cnt_width-1){1'b0}}, r_trig[i]};
        end
    end

    // Output, window and pulse-counter registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_trig      <= '0;
            r_active    <= 1'b0;
            r_win_cnt   <= 32'd0;
            r_pulse_cnt <= '0;
        end else begin
            r_trig      <= w_pulse & {g_trig_width{r_active}};
            r_active    <= w_active_nx;
            r_win_cnt   <= w_win_nx;
            r_pulse_cnt <= r_pulse_cnt + w_pop;
        end
    end

    assign trig_o      = r_trig;
    assign active_o    = r_active;
    assign pulse_cnt_o = r_pulse_cnt;

endmodule

// File: tb/tb_rmon_trig_gen_mc.sv
// Self-checking bench for rmon_trig_gen_mc: window vector table, then
// multi-cycle sequences checked against an event-time model of each channel.
module tb_rmon_trig_gen_mc;

    localparam int NCH = 10;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        en_i = 1'b0;
    logic [6:0]  prob_i = 7'd0;
    logic [31:0] run_len_i = 32'd0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic [9:0]  trig_o;
    logic        active_o;
    logic [31:0] pulse_cnt_o;

    rmon_trig_gen_mc dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .en_i        (en_i),
        .prob_i      (prob_i),
        .run_len_i   (run_len_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .trig_o      (trig_o),
        .active_o    (active_o),
        .pulse_cnt_o (pulse_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_err = 0;
    int n_chk = 0;

    // Model: next decision / pulse times per channel in enabled-cycle units
    longint      m_c;
    longint      m_pulse_at [NCH];
    longint      m_next_dec [NCH];
    logic [15:0] m_lfsr [NCH];
    logic [9:0]  m_trig;
    logic        m_active;
    logic [31:0] m_wcnt;
    logic [31:0] m_pcnt;

    logic   prev_active;
    bit     sp_on = 1'b0;
    longint sp_max;
    longint t_obs = 0;
    longint last_p [NCH];
    int     n_p [NCH];

    typedef struct {
        logic        en;
        logic        start;
        logic        stop;
        logic [31:0] len;
        logic        exp_active;
    } vec_t;
    vec_t tbl [22];

    logic [9:0] tr1 [400];

    function automatic logic [15:0] lfsr_nx(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] seed_of(input int n);
        logic [31:0] p;
        logic [15:0] s;
        p = 32'(n) * 32'h0000_1F35;
        s = 16'hACE1 ^ p[15:0];
        if (s == 16'h0000) s = 16'h0001;
        return s;
    endfunction

    function automatic longint idle_of(input logic [15:0] v);
        return longint'(v[15:13]) * 2;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_ok(input string name, input bit ok, input longint act, input string req);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d required %s (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_c = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            m_lfsr[ch]     = seed_of(ch);
            m_next_dec[ch] = 1;
            m_pulse_at[ch] = -1;
        end
        m_trig = '0; m_active = 1'b0; m_wcnt = 32'd0; m_pcnt = 32'd0;
    endtask

    // Predict register contents after the coming clock edge from current inputs
    task automatic model_eval();
        logic [9:0]  nt;
        logic [15:0] v;
        bit          fire;
        nt = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (en_i && m_c == m_pulse_at[ch]) nt[ch] = m_active;
            if (en_i && m_c == m_next_dec[ch]) begin
                fire = (prob_i == 7'h7F) || (m_lfsr[ch][6:0] < prob_i);
                if (fire) begin
                    m_pulse_at[ch] = m_c + 1;
                    v = m_lfsr[ch];
                    for (int k = 0; k < 31; k++) v = lfsr_nx(v);
                    m_next_dec[ch] = m_c + 33 + idle_of(v);
                end else begin
                    m_next_dec[ch] = m_c + 2 + idle_of(m_lfsr[ch]);
                end
            end
            if (en_i) m_lfsr[ch] = lfsr_nx(m_lfsr[ch]);
        end
        if (en_i) m_c++;
        m_pcnt = m_pcnt + 32'($countones(m_trig));
        m_trig = nt;
        if (stop_i) begin
            m_active = 1'b0; m_wcnt = 32'd0;
        end else if (start_i) begin
            m_active = 1'b1; m_wcnt = run_len_i;
        end else if (m_active && m_wcnt != 32'd0) begin
            if (m_wcnt == 32'd1) m_active = 1'b0;
            m_wcnt = m_wcnt - 32'd1;
        end
    endtask

    task automatic step();
        longint gap;
        model_eval();
        @(posedge clk_i);
        #1;
        t_obs++;
        chk("trig", 64'(trig_o), 64'(m_trig));
        chk("active", 64'(active_o), 64'(m_active));
        chk("pulse_cnt", 64'(pulse_cnt_o), 64'(m_pcnt));
        chk_ok("trig_outside_window", (trig_o == 10'd0) || prev_active, longint'(trig_o), "0 while closed");
        prev_active = active_o;
        if (sp_on) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (trig_o[ch]) begin
                    n_p[ch]++;
                    if (last_p[ch] >= 0) begin
                        gap = t_obs - last_p[ch];
                        chk_ok("spacing", gap >= 33 && gap <= sp_max, gap, "33..limit");
                    end
                    last_p[ch] = t_obs;
                end
            end
        end
    endtask

    task automatic cyc(input logic en, input logic [6:0] prob, input logic st,
                       input logic sp, input logic [31:0] len);
        en_i = en; prob_i = prob; start_i = st; stop_i = sp; run_len_i = len;
        step();
    endtask

    task automatic sp_start(input longint mx);
        sp_on = 1'b1; sp_max = mx;
        for (int ch = 0; ch < NCH; ch++) begin
            last_p[ch] = -1; n_p[ch] = 0;
        end
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        en_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; run_len_i = 32'd0; prob_i = 7'd0;
        model_reset();
        #2;
        chk("rst_trig", 64'(trig_o), 64'd0);
        chk("rst_active", 64'(active_o), 64'd0);
        chk("rst_pulse_cnt", 64'(pulse_cnt_o), 64'd0);
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b1;
        prev_active = 1'b0;
    endtask

    function automatic logic rp_en(input int i);
        return !(i >= 150 && i < 160);
    endfunction

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint sb;
        int     na, nz;
        bit     found;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'd3, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'd0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'd5, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'd5, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 32'd2, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 32'd1, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 32'd4, 1'b1};
        tbl[18] = '{1'b1, 1'b0, 1'b1, 32'd0, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 1'b1, 32'd7, 1'b0};
        tbl[20] = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b1};
        tbl[21] = '{1'b1, 1'b1, 1'b1, 32'd9, 1'b0};

        #1;
        do_reset();

        // Window vectors with prob 0: no pulses may ever appear
        for (int i = 0; i < 22; i++) begin
            cyc(tbl[i].en, 7'd0, tbl[i].start, tbl[i].stop, tbl[i].len);
            chk("tbl_active", 64'(active_o), 64'(tbl[i].exp_active));
            chk("tbl_trig", 64'(trig_o), 64'd0);
            chk("tbl_pulse_cnt", 64'(pulse_cnt_o), 64'd0);
        end

        for (int i = 0; i < 5000; i++) cyc(1'b1, 7'd0, i == 0, 1'b0, 32'd0);
        chk("never_fire_trig", 64'(trig_o), 64'd0);
        chk("never_fire_active", 64'(active_o), 64'd1);
        chk("never_fire_cnt", 64'(pulse_cnt_o), 64'd0);

        // Always fire: every channel pulses with spacing 33..47
        do_reset();
        sp_start(47);
        sb = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc(1'b1, 7'h7F, i == 0, 1'b0, 32'd0);
            sb += $countones(trig_o);
        end
        for (int ch = 0; ch < NCH; ch++) chk_ok("chan_pulsed", n_p[ch] > 0, n_p[ch], ">0");
        chk("scoreboard", 64'(pulse_cnt_o), 64'(sb - $countones(trig_o)));

        sp_start(64'd1 << 40);
        for (int i = 0; i < 12000; i++) cyc(1'b1, 7'h40, 1'b0, 1'b0, 32'd0);
        sp_on = 1'b0;

        // Window of 1000, then a restart at 500 with length 300
        cyc(1'b1, 7'h7F, 1'b0, 1'b1, 32'd0);
        na = 0;
        for (int i = 0; i < 1100; i++) begin
            cyc(1'b1, 7'h7F, i == 0, 1'b0, 32'd1000);
            if (active_o) na++;
        end
        chk("win_len_1000", 64'(na), 64'd1000);
        na = 0;
        for (int i = 0; i < 1100; i++) begin
            cyc(1'b1, 7'h7F, i == 0 || i == 500, 1'b0, (i == 500) ? 32'd300 : 32'd1000);
            if (active_o) na++;
            if (i == 799) chk("win_restart_last", 64'(active_o), 64'd1);
            if (i == 800) chk("win_restart_end", 64'(active_o), 64'd0);
        end
        chk("win_restart_len", 64'(na), 64'd800);

        // Freeze with en_i low mid-GAP while a 60-cycle window runs out
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            cyc(1'b1, 7'h7F, k == 0, 1'b0, 32'd0);
            if (trig_o[0]) found = 1'b1;
        end
        chk_ok("freeze_find_pulse", found, longint'(found), "pulse within 200 cycles");
        repeat (5) cyc(1'b1, 7'h7F, 1'b0, 1'b0, 32'd0);
        na = 0; nz = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(1'b0, 7'h7F, k == 0, 1'b0, 32'd60);
            if (active_o) na++;
            if (trig_o != 10'd0) nz++;
        end
        chk("freeze_active_len", 64'(na), 64'd60);
        chk("freeze_no_trig", 64'(nz), 64'd0);
        for (int k = 0; k < 300; k++) cyc(1'b1, 7'h7F, k == 0, 1'b0, 32'd0);

        // Deterministic replay across a reset taken while a channel is in PULSE
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc(rp_en(i), 7'h55, i == 0, 1'b0, 32'd0);
            tr1[i] = trig_o;
        end
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            cyc(1'b1, 7'h55, 1'b0, 1'b0, 32'd0);
            for (int ch = 0; ch < NCH; ch++) if (m_pulse_at[ch] == m_c) found = 1'b1;
        end
        chk_ok("replay_find_pulse_state", found, longint'(found), "PULSE within 200 cycles");
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc(rp_en(i), 7'h55, i == 0, 1'b0, 32'd0);
            chk("replay_trace", 64'(trig_o), 64'(tr1[i]));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rmon_trig_gen_mc.md
Name: rmon_trig_gen_mc

Overview:
- Synthesizable, multi-channel pseudo-random event-pulse generator that stimulates RMON/statistics counters in switch testbenches and on-FPGA self-test.
- Each channel independently emits single-cycle pulses with a programmable probability.
- After each pulse a channel enforces a minimum spacing equal to one minimum-size frame, then waits a random idle time.
- Emission is gated by a global run window (start/stop or a fixed cycle count), and the block counts every pulse it emits.

Parameters:
- g_trig_width, 10: number of independent trigger channels (1..32).
- g_prob_width, 7: width of the probability threshold prob_i.
- g_min_gap, 32: cycles from a pulse to the next decision (pulse cycle included); must be ≥2.
- g_idle_bits, 3: LFSR bits used for the random idle slot count (0..2^g_idle_bits-1 slots).
- g_idle_unit, 2: cycles per idle slot.
- g_cnt_width, 32: width of the emitted-pulse counter.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  channel FSM and LFSR advance enable; 0 freezes all state (no pulses).
- prob_i  in  g_prob_width  fire threshold; all-ones = always fire, 0 = never.
- run_len_i  in  32  window length in cycles, sampled on start_i; 0 = unlimited.
- start_i  in  1  one-cycle strobe; opens/restarts the run window.
- stop_i  in  1  one-cycle strobe; closes the window.
- trig_o  out  g_trig_width  per-channel single-cycle pulses.
- active_o  out  1  run window open.
- pulse_cnt_o  out  g_cnt_width  total pulses emitted on trig_o, all channels, since reset.

Behaviour:
- Reset, asynchronous: trig_o=0, active_o=0, pulse_cnt_o=0, window counter=0, every channel in IDLE with idle count 0, LFSRs loaded with seeds.
- LFSR per channel:
  - 16-bit Fibonacci, taps 16,14,13,11, shift toward MSB.
  - Seed = 16'hACE1 ^ (n*16'h1F35) truncated to 16 bits; a zero result is replaced by 16'h0001.
  - Advances every cycle in which en_i=1.
- Channel FSM, advancing only when en_i=1:
  - IDLE:
    - While idle count > 0, decrement it.
    - When idle count = 0, go to DECIDE.
  - DECIDE (1 cycle):
    - fire = (prob_i all-ones) or (lfsr[g_prob_width-1:0] < prob_i).
    - If fire, go to PULSE.
    - Otherwise load idle = lfsr[15:16-g_idle_bits] * g_idle_unit and go to IDLE.
  - PULSE (1 cycle):
    - Internal pulse = 1.
    - Load gap counter with g_min_gap-2, then go to GAP.
  - GAP:
    - Decrement the gap counter.
    - At 0, load idle as in DECIDE and go to IDLE.
- Consequence: two pulses on one channel are ≥ g_min_gap+1 cycles apart (PULSE, GAP, at least one DECIDE).
- trig_o:
  - trig_o[n] is registered: equal to (state==PULSE) & active in the previous cycle; latency 1.
  - Channels run and consume randomness even when the window is closed, so the pulse pattern is independent of window timing.
- Window:
  - start_i with run_len_i=N>0: active=1 and counter=N from the next cycle; active clears after exactly N active cycles.
  - start_i with run_len_i=0: active stays 1 until stop_i.
  - start_i while already active: restarts with the new length.
  - stop_i: active=0 next cycle. When start_i and stop_i coincide, stop wins.
  - The window counts regardless of en_i.
- pulse_cnt_o:
  - Adds popcount(trig_o) each cycle; it lags trig_o by one cycle.
  - Wraps modulo 2^g_cnt_width; no saturation.
- Reset mid-operation: all state returns to reset values immediately and any in-flight pulse is dropped.
- After reset, the LFSR sequence repeats identically (deterministic replay).

Decomposition:
- Package rmon_trig_pkg: channel state enum (IDLE, DECIDE, PULSE, GAP), LFSR tap mask, seed base and stride constants, seed function (index → non-zero seed).
- Sub-module rmon_trig_chan: one channel, i.e. LFSR + FSM + counters, with seed as a parameter.
- Top-level: instantiates g_trig_width channels, the window logic and the popcount accumulator.

Test Plan:
- Reset, then en_i=1, start_i with run_len_i=0, prob_i=0, for 10000 cycles → trig_o all-zero, pulse_cnt_o=0, active_o=1.
- prob_i=7'h7F, g_idle_unit=2, unlimited window, 2000 cycles → every channel pulses; per-channel spacing ≥33 cycles and ≤33+14; pulse_cnt_o equals a scoreboard count.
- prob_i=7'h40 for 200000 cycles → per-channel decision hit rate 50%±2%; no spacing <33.
- start_i with run_len_i=1000 → active_o high exactly 1000 cycles; no trig_o outside; start_i at cycle 500 with run_len_i=300 → active ends at cycle 800; start_i and stop_i together → active_o=0.
- en_i=0 for 100 cycles mid-GAP → no pulses, state frozen; resumes with the same LFSR sequence; window still expires on time.
- Assert rst_n_i mid-PULSE, release, repeat the identical stimulus → trig_o trace bit-identical to the first post-reset run; pulse_cnt_o=0 during reset.
